// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NREQ producers, bursts of up to MAX_BURST beats.
// Define FIFO_ARB_STATS_EN to add per-requester saturating accepted-beat counters on beat_cnt.
module fifo_wr_arb #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DATA_WIDTH-1:0]   din,
  output logic [NREQ-1:0]              gnt,
  output logic                         busy,
  output logic [$clog2(NREQ)-1:0]      owner,
  output logic                         fifo_we,
  output logic [DATA_WIDTH-1:0]        fifo_datain,
  input  logic                         fifo_full
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]           beat_cnt
`endif
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] bcnt;
  logic [OW-1:0] winner;
  logic          found;
  logic          beat;
  int unsigned   idx;

  // Search starts just after the last owner and wraps back to it, giving rotating priority.
  always_comb begin
    winner = owner;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(owner) + k) % 32'(NREQ);
      if (!found && req[OW'(idx)]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign beat        = (state == OWN) && req[owner] && !fifo_full;
  assign fifo_we     = beat;
  assign busy        = (state == OWN);
  assign fifo_datain = din[32'(owner)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    gnt = '0;
    if (beat) gnt[owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= OW'(NREQ - 1);
      bcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= winner;
            bcnt  <= '0;
            state <= OWN;
          end
        end
        default: begin
          if (!req[owner]) begin
            state <= IDLE;
          end else if (beat) begin
            bcnt <= bcnt + CW'(1);
            if (bcnt == CW'(MAX_BURST - 1)) state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++)
        if (gnt[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 16'd1;
    end
  end

  always_comb begin
    beat_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) beat_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: vector table for basic and round-robin bursts, hand sequences for stall, async reset, drop.
// With FIFO_ARB_STATS_EN defined the beat_cnt counters are also checked.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  owner;
  logic        fifo_we;
  logic [7:0]  fifo_datain;
  logic        fifo_full;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] beat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] DD = 32'hD3D2D1D0;

  fifo_wr_arb #(.NREQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .din         (din),
    .gnt         (gnt),
    .busy        (busy),
    .owner       (owner),
    .fifo_we     (fifo_we),
    .fifo_datain (fifo_datain),
    .fifo_full   (fifo_full)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_cnt    (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic        full;
    logic [3:0]  gnt;
    logic        we;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [3:0] eg, input logic ew,
                          input logic eb, input logic [1:0] eo, input logic [7:0] ed);
    chk({nm, " gnt"}, 64'(gnt), 64'(eg));
    chk({nm, " we"}, 64'(fifo_we), 64'(ew));
    chk({nm, " busy"}, 64'(busy), 64'(eb));
    chk({nm, " owner"}, 64'(owner), 64'(eo));
    if (ew) chk({nm, " data"}, 64'(fifo_datain), 64'(ed));
  endtask

  // One clock cycle: drive after the edge, check on the falling edge, advance.
  task automatic cyc(input string nm, input logic r, input logic [3:0] q, input logic [31:0] d,
                     input logic f, input logic [3:0] eg, input logic ew, input logic eb,
                     input logic [1:0] eo, input logic [7:0] ed);
    rst = r; req = q; din = d; fifo_full = f;
    @(negedge clk);
    chk_outs(nm, eg, ew, eb, eo, ed);
    @(posedge clk); #1;
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [31:0] d, input logic f,
                     input logic [3:0] eg, input logic ew, input logic eb,
                     input logic [1:0] eo, input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.req = q; v.din = d; v.full = f;
    v.gnt = eg; v.we = ew; v.busy = eb; v.owner = eo; v.data = ed;
    tbl.push_back(v);
  endtask

  initial begin
    logic [1:0] seq [5];
    logic [7:0] dv;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;

    // Single requester, three beats A1..A3, then release.
    add(0, 4'b0001, 32'h000000A1, 0, 4'b0000, 0, 0, 2'd3, 8'h00);
    add(0, 4'b0001, 32'h000000A1, 0, 4'b0001, 1, 1, 2'd0, 8'hA1);
    add(0, 4'b0001, 32'h000000A2, 0, 4'b0001, 1, 1, 2'd0, 8'hA2);
    add(0, 4'b0001, 32'h000000A3, 0, 4'b0001, 1, 1, 2'd0, 8'hA3);
    add(0, 4'b0000, 32'h000000A3, 0, 4'b0000, 0, 1, 2'd0, 8'h00);
    add(0, 4'b0000, 32'h000000A3, 0, 4'b0000, 0, 0, 2'd0, 8'h00);
    // Reset, then all four requesting: owners 0,1,2,3,0 with 4 beats and one bubble each.
    add(1, 4'b1111, DD, 0, 4'b0000, 0, 0, 2'd3, 8'h00);
    add(0, 4'b1111, DD, 0, 4'b0000, 0, 0, 2'd3, 8'h00);
    for (int b = 0; b < 5; b++) begin
      dv = DD[8*seq[b] +: 8];
      for (int j = 0; j < 4; j++)
        add(0, 4'b1111, DD, 0, 4'(1 << seq[b]), 1, 1, seq[b], dv);
      add(0, (b == 4) ? 4'b0000 : 4'b1111, DD, 0, 4'b0000, 0, 0, seq[b], 8'h00);
    end

    rst = 1'b1; req = '0; din = '0; fifo_full = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk_outs("reset", 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00);
    @(posedge clk); #1;

    foreach (tbl[i])
      cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, tbl[i].din, tbl[i].full,
          tbl[i].gnt, tbl[i].we, tbl[i].busy, tbl[i].owner, tbl[i].data);

`ifdef FIFO_ARB_STATS_EN
    chk("beat_cnt", beat_cnt, {16'd4, 16'd4, 16'd4, 16'd8});
`endif

    // Owner 2 stalled by full for 5 cycles mid-burst; burst still totals 4 beats.
    cyc("s3 idle", 0, 4'b0100, DD, 0, 4'b0000, 0, 0, 2'd0, 8'h00);
    cyc("s3 b1",   0, 4'b0100, DD, 0, 4'b0100, 1, 1, 2'd2, 8'hD2);
    cyc("s3 b2",   0, 4'b0100, DD, 0, 4'b0100, 1, 1, 2'd2, 8'hD2);
    for (int s = 0; s < 5; s++)
      cyc($sformatf("s3 stall%0d", s), 0, 4'b0100, DD, 1, 4'b0000, 0, 1, 2'd2, 8'h00);
    cyc("s3 b3",   0, 4'b0100, DD, 0, 4'b0100, 1, 1, 2'd2, 8'hD2);
    cyc("s3 b4",   0, 4'b0100, DD, 0, 4'b0100, 1, 1, 2'd2, 8'hD2);
    cyc("s3 end",  0, 4'b0000, DD, 0, 4'b0000, 0, 0, 2'd2, 8'h00);

    // Async reset pulse between edges during owner 1's second beat.
    cyc("s4 idle", 0, 4'b0010, DD, 0, 4'b0000, 0, 0, 2'd2, 8'h00);
    cyc("s4 b1",   0, 4'b0010, DD, 0, 4'b0010, 1, 1, 2'd1, 8'hD1);
    #1;
    chk_outs("s4 b2", 4'b0010, 1'b1, 1'b1, 2'd1, 8'hD1);
    #2 rst = 1'b1;
    #1;
    chk_outs("s4 inrst", 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00);
    #2 rst = 1'b0; req = 4'b0011;
    @(posedge clk); #1;
    cyc("s4 regrant", 0, 4'b0011, DD, 0, 4'b0001, 1, 1, 2'd0, 8'hD0);
    cyc("s4 drop",    0, 4'b0000, DD, 0, 4'b0000, 0, 1, 2'd0, 8'h00);
    cyc("s4 end",     0, 4'b0000, DD, 0, 4'b0000, 0, 0, 2'd0, 8'h00);

    // Requester 3 drops after one beat while requester 1 waits.
    cyc("s5 idle", 0, 4'b1000, DD, 0, 4'b0000, 0, 0, 2'd0, 8'h00);
    cyc("s5 b1",   0, 4'b1010, DD, 0, 4'b1000, 1, 1, 2'd3, 8'hD3);
    cyc("s5 drop", 0, 4'b0010, DD, 0, 4'b0000, 0, 1, 2'd3, 8'h00);
    cyc("s5 bub",  0, 4'b0010, DD, 0, 4'b0000, 0, 0, 2'd3, 8'h00);
    cyc("s5 r1",   0, 4'b0010, DD, 0, 4'b0010, 1, 1, 2'd1, 8'hD1);
    cyc("s5 rel",  0, 4'b0000, DD, 0, 4'b0000, 0, 1, 2'd1, 8'h00);
    cyc("s5 end",  0, 4'b0000, DD, 0, 4'b0000, 0, 0, 2'd1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
